// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_pkg
//  Description : Shared definitions for the data-memory access sequencer.
//                Holds the FSM state encoding, access size codes, the MIPS
//                ExcCode values the sequencer can raise, and the alignment
//                helper used by the fault check.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;
    localparam logic [1:0] c_SIZE_RSVD = 2'd3;

    localparam logic [4:0] c_EXC_MOD  = 5'd1;
    localparam logic [4:0] c_EXC_TLBL = 5'd2;
    localparam logic [4:0] c_EXC_TLBS = 5'd3;
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;
    localparam logic [4:0] c_EXC_DBE  = 5'd7;

    // Natural-alignment check; bytes are always aligned.
    function automatic logic addr_misaligned(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic w_mis;
        w_mis = 1'b0;
        if (size == c_SIZE_HALF)
            w_mis = addr_lo[0];
        else if (size == c_SIZE_WORD)
            w_mis = (addr_lo != 2'b00);
        return w_mis;
    endfunction

endpackage : mem_access_ctrl_pkg
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering for a 32-bit little-endian
//                data bus.
//                  size, addr_lo  - access size code and byte offset
//                  sign           - sign-extend load data when set
//                  wdata          - right-justified store data
//                  rdata          - raw bus read word
//                  be             - byte enables
//                  wdata_lane     - store data replicated across lanes
//                  rdata_ext      - load data shifted down and extended
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    // Only the low halfword of the shifted word is ever consumed.
    logic [15:0] w_shifted;

    always_comb begin
        w_shifted  = 16'(rdata >> {addr_lo, 3'b000});
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        case (size)
            c_SIZE_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign & w_shifted[7]}}, w_shifted[7:0]};
            end
            c_SIZE_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                // Word (and the never-issued reserved size) pass through.
            end
        endcase
    end

endmodule : mem_lane_align
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Data-memory access sequencer following the virtual memory
//                map stage. Picks the physical address, checks alignment,
//                privilege and TLB faults, runs a single bus transaction
//                with a timeout, aligns load data and reports either a
//                response or an exception. Stalls the pipeline meanwhile.
//  Ports       : req_*  - pipeline load/store request
//                map_*  - direct-map results from the map stage
//                tlb_*  - TLB lookup result
//                bus_*  - single-transaction data bus
//                stall  - pipeline freeze
//                resp_* - one-cycle completion with aligned load data
//                exc_*  - one-cycle exception with ExcCode and BadVAddr
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_vaddr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] map_paddr,
    input  logic        map_using_tlb,
    input  logic        map_invalid,
    input  logic        map_uncached,
    input  logic [31:0] tlb_paddr,
    input  logic        tlb_miss,
    input  logic        tlb_valid,
    input  logic        tlb_dirty,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        bus_uncached,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_valid,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_badvaddr
);

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_vaddr;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [1:0]  r_addr_lo;
    logic        r_we;
    logic [4:0]  r_exc_code;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_uncached;
    logic [7:0]  r_cnt;
    logic [31:0] r_rdata;

    logic [31:0] w_paddr;
    logic        w_fault;
    logic [4:0]  w_fault_code;
    logic        w_idle;
    logic [1:0]  w_lane_size;
    logic [1:0]  w_lane_addr;
    logic        w_lane_sign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lane;
    logic [31:0] w_rdata_ext;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_paddr = map_using_tlb ? tlb_paddr : map_paddr;

    // Fault check on the incoming request, highest priority first.
    always_comb begin
        w_fault      = 1'b1;
        w_fault_code = c_EXC_MOD;
        if (addr_misaligned(req_size, req_vaddr[1:0]) ||
            (req_size == c_SIZE_RSVD) || map_invalid)
            w_fault_code = req_we ? c_EXC_ADES : c_EXC_ADEL;
        else if (map_using_tlb && (tlb_miss || !tlb_valid))
            w_fault_code = req_we ? c_EXC_TLBS : c_EXC_TLBL;
        else if (map_using_tlb && req_we && !tlb_dirty)
            w_fault_code = c_EXC_MOD;
        else
            w_fault = 1'b0;
    end

    // One lane aligner serves both directions: in IDLE it shapes the
    // outgoing store from the live request, in ACCESS it extracts the load
    // from the latched access attributes. The byte offset comes from the
    // physical address; it equals the virtual offset within a page.
    assign w_lane_size = w_idle ? req_size     : r_size;
    assign w_lane_addr = w_idle ? w_paddr[1:0] : r_addr_lo;
    assign w_lane_sign = w_idle ? req_sign     : r_sign;

    mem_lane_align u_lane_align (
        .size       (w_lane_size),
        .addr_lo    (w_lane_addr),
        .sign       (w_lane_sign),
        .wdata      (req_wdata),
        .rdata      (bus_rdata),
        .be         (w_be),
        .wdata_lane (w_wdata_lane),
        .rdata_ext  (w_rdata_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_vaddr    <= 32'd0;
            r_size     <= 2'd0;
            r_sign     <= 1'b0;
            r_addr_lo  <= 2'd0;
            r_we       <= 1'b0;
            r_exc_code <= 5'd0;
            r_bus_addr <= 32'd0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_uncached <= 1'b0;
            r_cnt      <= 8'd0;
            r_rdata    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_vaddr <= req_vaddr;
                        if (w_fault) begin
                            r_exc_code <= w_fault_code;
                            r_state    <= ST_FAULT;
                        end else begin
                            r_size     <= req_size;
                            r_sign     <= req_sign;
                            r_addr_lo  <= w_paddr[1:0];
                            r_we       <= req_we;
                            r_bus_addr <= {w_paddr[31:2], 2'b00};
                            r_be       <= w_be;
                            r_wdata    <= w_wdata_lane;
                            // kseg1 only; translated pages are cached here.
                            r_uncached <= map_uncached & ~map_using_tlb;
                            r_state    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (bus_err) begin
                        // An error wins even when ack arrives alongside it.
                        r_exc_code <= c_EXC_DBE;
                        r_cnt      <= 8'd0;
                        r_state    <= ST_FAULT;
                    end else if (bus_ack) begin
                        r_rdata <= w_rdata_ext;
                        r_cnt   <= 8'd0;
                        r_state <= ST_RESP;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        r_exc_code <= c_EXC_DBE;
                        r_cnt      <= 8'd0;
                        r_state    <= ST_FAULT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    // The request is still held by the stalled pipeline
                    // during this cycle; return to IDLE without taking it.
                    r_state <= ST_IDLE;
                end
                ST_FAULT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_req      = (r_state == ST_ACCESS);
    assign bus_we       = r_we;
    assign bus_addr     = r_bus_addr;
    assign bus_be       = r_be;
    assign bus_wdata    = r_wdata;
    assign bus_uncached = r_uncached;

    assign stall        = (w_idle & req_valid) | (r_state == ST_ACCESS);
    assign resp_valid   = (r_state == ST_RESP);
    assign resp_rdata   = r_rdata;
    assign exc_valid    = (r_state == ST_FAULT);
    assign exc_code     = r_exc_code;
    assign exc_badvaddr = r_vaddr;

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl: a table of
//                directed requests with hand-computed bus/response/exception
//                values, plus sequences for bus error, timeout and reset
//                during an access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_vaddr, req_wdata, map_paddr, tlb_paddr;
    logic        map_using_tlb, map_invalid, map_uncached;
    logic        tlb_miss, tlb_valid, tlb_dirty;
    logic        bus_req, bus_we, bus_uncached, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        stall, resp_valid, exc_valid;
    logic [31:0] resp_rdata, exc_badvaddr;
    logic [4:0]  exc_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_sign(req_sign), .req_vaddr(req_vaddr), .req_wdata(req_wdata),
        .map_paddr(map_paddr), .map_using_tlb(map_using_tlb),
        .map_invalid(map_invalid), .map_uncached(map_uncached),
        .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss), .tlb_valid(tlb_valid),
        .tlb_dirty(tlb_dirty),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_uncached(bus_uncached),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [31:0] map_paddr;
        logic        using_tlb;
        logic        invalid;
        logic        uncached;
        logic [31:0] tlb_paddr;
        logic        miss;
        logic        valid;
        logic        dirty;
        int          ack_delay;
        logic [31:0] rdata;
        logic        fault;
        logic [4:0]  code;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        unc;
        logic [31:0] resp;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_we        = v.we;
        req_size      = v.size;
        req_sign      = v.sign;
        req_vaddr     = v.vaddr;
        req_wdata     = v.wdata;
        map_paddr     = v.map_paddr;
        map_using_tlb = v.using_tlb;
        map_invalid   = v.invalid;
        map_uncached  = v.uncached;
        tlb_paddr     = v.tlb_paddr;
        tlb_miss      = v.miss;
        tlb_valid     = v.valid;
        tlb_dirty     = v.dirty;
        req_valid     = 1'b1;
    endtask

    task automatic apply_vec(input int i, input vec_t v);
        @(negedge clk);
        drive_req(v);
        #1 check($sformatf("v%0d stall_on_req", i), stall, 1);
        @(posedge clk); #1;
        if (v.fault) begin
            check($sformatf("v%0d exc_valid", i), exc_valid, 1);
            check($sformatf("v%0d exc_code", i), exc_code, v.code);
            check($sformatf("v%0d badvaddr", i), exc_badvaddr, v.vaddr);
            check($sformatf("v%0d no_bus_req", i), bus_req, 0);
            check($sformatf("v%0d stall_fault", i), stall, 0);
            req_valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("v%0d exc_pulse_end", i), exc_valid, 0);
        end else begin
            check($sformatf("v%0d bus_req", i), bus_req, 1);
            check($sformatf("v%0d bus_addr", i), bus_addr, v.addr);
            check($sformatf("v%0d bus_be", i), bus_be, v.be);
            check($sformatf("v%0d bus_wdata", i), bus_wdata, v.bwdata);
            check($sformatf("v%0d bus_we", i), bus_we, v.we);
            check($sformatf("v%0d bus_uncached", i), bus_uncached, v.unc);
            for (int k = 0; k < v.ack_delay; k++) begin
                @(posedge clk); #1;
            end
            check($sformatf("v%0d stall_access", i), stall, 1);
            check($sformatf("v%0d bus_req_held", i), bus_req, 1);
            bus_ack   = 1'b1;
            bus_rdata = v.rdata;
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = 32'd0;
            check($sformatf("v%0d resp_valid", i), resp_valid, 1);
            check($sformatf("v%0d resp_rdata", i), resp_rdata, v.resp);
            check($sformatf("v%0d stall_resp", i), stall, 0);
            check($sformatf("v%0d bus_req_drop", i), bus_req, 0);
            // Request still asserted through RESP: must not be re-accepted.
            @(posedge clk); #1;
            check($sformatf("v%0d resp_pulse_end", i), resp_valid, 0);
            check($sformatf("v%0d no_reaccept", i), bus_req, 0);
            req_valid = 1'b0;
            #1 check($sformatf("v%0d stall_idle", i), stall, 0);
        end
    endtask

    initial begin
        int cyc;

        //          we size sg vaddr         wdata         map_paddr
        //          tlb inv unc tlb_paddr    miss vld drt  dly rdata
        //          flt code addr            be    bwdata        unc resp
        vecs[0]  = '{0, 2, 0, 32'h80001004, 32'h0,        32'h00001004,
                     0, 0, 0, 32'h0,         0, 0, 0,      3, 32'hDEADBEEF,
                     0, 0, 32'h00001004,     4'hF, 32'h0,        0, 32'hDEADBEEF};
        vecs[1]  = '{0, 0, 1, 32'h80000003, 32'h0,        32'h00000003,
                     0, 0, 0, 32'h0,         0, 0, 0,      0, 32'h80FFFFFF,
                     0, 0, 32'h00000000,     4'h8, 32'h0,        0, 32'hFFFFFF80};
        vecs[2]  = '{0, 0, 0, 32'h80000003, 32'h0,        32'h00000003,
                     0, 0, 0, 32'h0,         0, 0, 0,      1, 32'h80FFFFFF,
                     0, 0, 32'h00000000,     4'h8, 32'h0,        0, 32'h00000080};
        vecs[3]  = '{1, 1, 0, 32'hA0000002, 32'h00001234, 32'h00000002,
                     0, 0, 1, 32'h0,         0, 0, 0,      0, 32'h0,
                     0, 0, 32'h00000000,     4'hC, 32'h12341234, 1, 32'h0};
        vecs[4]  = '{0, 1, 1, 32'h00400002, 32'h0,        32'h0,
                     1, 0, 1, 32'h12345002,  0, 1, 0,      2, 32'h80017FFF,
                     0, 0, 32'h12345000,     4'hC, 32'h0,        0, 32'hFFFF8001};
        vecs[5]  = '{1, 0, 0, 32'h00400005, 32'h000000AB, 32'h0,
                     1, 0, 0, 32'h00002005,  0, 1, 1,      1, 32'h0,
                     0, 0, 32'h00002004,     4'h2, 32'hABABABAB, 0, 32'h0};
        vecs[6]  = '{0, 1, 0, 32'h80000010, 32'h0,        32'h00000010,
                     0, 0, 0, 32'h0,         0, 0, 0,      0, 32'h1234ABCD,
                     0, 0, 32'h00000010,     4'h3, 32'h0,        0, 32'h0000ABCD};
        vecs[7]  = '{0, 2, 0, 32'h00400001, 32'h0,        32'h0,
                     1, 0, 0, 32'h0,         1, 0, 0,      0, 32'h0,
                     1, 4, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[8]  = '{0, 2, 0, 32'h80000000, 32'h0,        32'h0,
                     1, 1, 0, 32'h0,         1, 0, 0,      0, 32'h0,
                     1, 4, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[9]  = '{1, 2, 0, 32'h00400008, 32'h5,        32'h0,
                     1, 0, 0, 32'h00003008,  0, 1, 0,      0, 32'h0,
                     1, 1, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[10] = '{1, 2, 0, 32'h0040000C, 32'h5,        32'h0,
                     1, 0, 0, 32'h0000300C,  1, 1, 0,      0, 32'h0,
                     1, 3, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[11] = '{0, 2, 0, 32'h00400010, 32'h0,        32'h0,
                     1, 0, 0, 32'h00003010,  0, 0, 0,      0, 32'h0,
                     1, 2, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[12] = '{1, 3, 0, 32'h00000020, 32'h0,        32'h00000020,
                     0, 0, 0, 32'h0,         0, 0, 0,      0, 32'h0,
                     1, 5, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[13] = '{1, 1, 0, 32'h80000021, 32'h0,        32'h00000021,
                     0, 0, 0, 32'h0,         0, 0, 0,      0, 32'h0,
                     1, 5, 32'h0,            4'h0, 32'h0,        0, 32'h0};
        vecs[14] = '{0, 0, 1, 32'h80000032, 32'h0,        32'h00000032,
                     0, 0, 0, 32'h0,         0, 0, 0,      0, 32'h00C30000,
                     0, 0, 32'h00000030,     4'h4, 32'h0,        0, 32'hFFFFFFC3};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
        req_vaddr = 32'd0; req_wdata = 32'd0; map_paddr = 32'd0;
        map_using_tlb = 1'b0; map_invalid = 1'b0; map_uncached = 1'b0;
        tlb_paddr = 32'd0; tlb_miss = 1'b0; tlb_valid = 1'b0; tlb_dirty = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst bus_req", bus_req, 0);
        check("rst bus_addr", bus_addr, 0);
        check("rst bus_be", bus_be, 0);
        check("rst resp_rdata", resp_rdata, 0);
        check("rst exc_code", exc_code, 0);
        check("rst exc_badvaddr", exc_badvaddr, 0);
        check("rst stall", stall, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++)
            apply_vec(i, vecs[i]);

        // Bus error arriving together with ack -> DBE, no response.
        @(negedge clk);
        drive_req(vecs[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #1;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        check("berr exc_valid", exc_valid, 1);
        check("berr exc_code", exc_code, 7);
        check("berr resp_valid", resp_valid, 0);
        check("berr bus_req", bus_req, 0);
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Timeout: no ack, bus_req must stay up exactly 255 cycles.
        @(negedge clk);
        drive_req(vecs[6]);
        @(posedge clk); #1;
        cyc = 0;
        while (bus_req && cyc < 400) begin
            cyc++;
            @(posedge clk); #1;
        end
        check("tmo bus_req_cycles", cyc, 255);
        check("tmo exc_valid", exc_valid, 1);
        check("tmo exc_code", exc_code, 7);
        check("tmo badvaddr", exc_badvaddr, 32'h80000010);
        check("tmo bus_req_low", bus_req, 0);
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an access.
        @(negedge clk);
        drive_req(vecs[3]);
        @(posedge clk); #1;
        check("arst pre bus_req", bus_req, 1);
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst bus_req", bus_req, 0);
        check("arst bus_we", bus_we, 0);
        check("arst bus_addr", bus_addr, 0);
        check("arst bus_uncached", bus_uncached, 0);
        check("arst stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        // Back to normal operation after reset.
        apply_vec(100, vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_access_ctrl
`default_nettype wire
